// File: rtl/iob_ila_seq_pkg.sv
// iob_ila_seq_pkg
//   Shared definitions for the sequenced ILA capture core.
//   - state_t        : capture FSM encoding (IDLE..DONE)
//   - IOB_ILA_SEQ_ENTRY_W(sig_w, ts_w)   : width of one buffer entry
//   - IOB_ILA_SEQ_N_WORDS(entry_w, data_w): readback words per entry
//   Build option: IOB_ILA_SEQ_TIMESTAMP_EN adds a TS_W timestamp above the
//   probe bits of each entry.
`ifndef IOB_ILA_SEQ_PKG_SV
`define IOB_ILA_SEQ_PKG_SV

`ifdef IOB_ILA_SEQ_TIMESTAMP_EN
`define IOB_ILA_SEQ_ENTRY_W(sig_w, ts_w) ((sig_w) + (ts_w))
`else
// The timestamp width stays referenced (times zero) so both builds use it.
`define IOB_ILA_SEQ_ENTRY_W(sig_w, ts_w) ((sig_w) + 0 * (ts_w))
`endif

`define IOB_ILA_SEQ_N_WORDS(entry_w, data_w) (((entry_w) + (data_w) - 1) / (data_w))

package iob_ila_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

`endif

// File: rtl/iob_ila_seq_mem.sv
// iob_ila_seq_mem
//   DEPTH x WIDTH sample buffer: one synchronous write port, one read port
//   with a registered output.
//   Ports:
//     clk_i    : clock
//     arst_n_i : asynchronous active-low reset (clears the read register only)
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address
//     rdata_o  : read data, one cycle after raddr_i
module iob_ila_seq_mem
  import iob_ila_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_array[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_array[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_ila_seq_core.sv
// iob_ila_seq_core
//   Sequenced capture core of the integrated logic analyser. Samples the
//   probe bus into a circular buffer with a programmable pre-trigger window;
//   the trigger is a chain of up to N_STAGES masked pattern matches.
//   Ports:
//     clk_i, cke_i, arst_n_i      : clock, clock enable, async active-low reset
//     signal_i, trigger_i         : probe bus and trigger inputs
//     arm_i, abort_i              : start/restart capture, return to IDLE
//     pre_samples_i               : samples kept before the trigger
//     n_stages_i                  : active sequencer stages (0 = immediate)
//     stage_mask_i/stage_value_i  : per-stage care mask / match value
//     rd_addr_i, rd_sel_i         : logical sample index, word select
//     rd_data_o                   : registered readback word
//     state_o, stage_o            : FSM state, current sequencer stage
//     trig_addr_o, done_o         : physical trigger address, capture done
//   Build option: IOB_ILA_SEQ_TIMESTAMP_EN stores {timestamp, signal} entries.
module iob_ila_seq_core
  import iob_ila_seq_pkg::*;
#(
  parameter int SIGNAL_W  = 32,
  parameter int TRIGGER_W = 4,
  parameter int BUFFER_W  = 10,
  parameter int N_STAGES  = 4,
  parameter int DATA_W    = 32,
  parameter int TS_W      = 16,
  parameter int STG_W     = $clog2(N_STAGES + 1)
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_n_i,
  input  logic [SIGNAL_W-1:0]           signal_i,
  input  logic [TRIGGER_W-1:0]          trigger_i,
  input  logic                          arm_i,
  input  logic                          abort_i,
  input  logic [BUFFER_W-1:0]           pre_samples_i,
  input  logic [STG_W-1:0]              n_stages_i,
  input  logic [N_STAGES*TRIGGER_W-1:0] stage_mask_i,
  input  logic [N_STAGES*TRIGGER_W-1:0] stage_value_i,
  input  logic [BUFFER_W-1:0]           rd_addr_i,
  input  logic [7:0]                    rd_sel_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic [2:0]                    state_o,
  output logic [STG_W-1:0]              stage_o,
  output logic [BUFFER_W-1:0]           trig_addr_o,
  output logic                          done_o
);

  localparam int ENTRY_W = `IOB_ILA_SEQ_ENTRY_W(SIGNAL_W, TS_W);
  localparam int N_WORDS = `IOB_ILA_SEQ_N_WORDS(ENTRY_W, DATA_W);

  state_t              state_q, state_d;
  logic [BUFFER_W-1:0] wptr_q, wptr_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  logic [BUFFER_W-1:0] cnt_q, cnt_d;
  logic [BUFFER_W-1:0] pre_q, pre_d;
  logic [BUFFER_W-1:0] trig_addr_q, trig_addr_d;
  logic [7:0]          rd_sel_q;

  logic                wr_en;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [BUFFER_W-1:0] rd_phys;
  logic [BUFFER_W-1:0] cnt_inc;
  logic [BUFFER_W-1:0] post_len;
  logic [STG_W-1:0]    n_eff;
  logic                last_stage;
  logic [N_STAGES-1:0] stage_hit;
  logic                cur_hit;

  // ---------------------------------------------------------------------
  // Trigger stage matching: every stage is evaluated in parallel and the
  // current one is picked afterwards.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    assign stage_hit[gi] =
        &(~(trigger_i ^ stage_value_i[gi*TRIGGER_W +: TRIGGER_W])
          | ~stage_mask_i[gi*TRIGGER_W +: TRIGGER_W]);
  end

  always_comb begin
    cur_hit = 1'b0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (stage_q == STG_W'(k)) begin
        cur_hit = stage_hit[k];
      end
    end
  end

  assign n_eff      = (n_stages_i > STG_W'(N_STAGES)) ? STG_W'(N_STAGES) : n_stages_i;
  // stage_q never exceeds N_STAGES-1, so the increment cannot overflow STG_W.
  assign last_stage = (stage_q + STG_W'(1)) >= n_eff;
  assign cnt_inc    = cnt_q + BUFFER_W'(1);
  // DEPTH-1-P computed in BUFFER_W bits is simply the bitwise inverse of P.
  assign post_len   = ~pre_q;

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    wr_en       = 1'b0;

    if (cke_i) begin
      if (abort_i) begin
        state_d = ST_IDLE;
      end else if (arm_i) begin
        wptr_d  = '0;
        stage_d = '0;
        cnt_d   = '0;
        // pre_samples_i already tops out at DEPTH-1, so it is P as-is.
        pre_d   = pre_samples_i;
        state_d = (pre_samples_i == '0) ? ST_WAIT : ST_PRE;
      end else begin
        case (state_q)
          ST_PRE: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + BUFFER_W'(1);
            if (cnt_inc == pre_q) begin
              cnt_d   = '0;
              state_d = ST_WAIT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_WAIT: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + BUFFER_W'(1);
            if ((n_eff == '0) || (cur_hit && last_stage)) begin
              // The sample written this cycle is the trigger sample.
              trig_addr_d = wptr_q;
              cnt_d       = '0;
              state_d     = (post_len == '0) ? ST_DONE : ST_POST;
            end else if (cur_hit) begin
              stage_d = stage_q + STG_W'(1);
            end
          end
          ST_POST: begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + BUFFER_W'(1);
            if (cnt_inc == post_len) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      stage_q     <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      rd_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
      // Readback is independent of cke_i.
      rd_sel_q    <= rd_sel_i;
    end
  end

  // ---------------------------------------------------------------------
  // Entry assembly (optional timestamp)
  // ---------------------------------------------------------------------
`ifdef IOB_ILA_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (cke_i) begin
      if (arm_i && !abort_i) begin
        ts_d = '0;
      end else begin
        ts_d = ts_q + TS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_entry = {ts_q, signal_i};
`else
  assign wr_entry = signal_i;
`endif

  // ---------------------------------------------------------------------
  // Sample buffer and readback
  // ---------------------------------------------------------------------
  // Logical index 0 is the oldest kept sample: P entries before the trigger.
  assign rd_phys = trig_addr_q - pre_q + rd_addr_i;

  iob_ila_seq_mem #(
    .ADDR_W (BUFFER_W),
    .WIDTH  (ENTRY_W)
  ) u_mem (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .we_i     (wr_en),
    .waddr_i  (wptr_q),
    .wdata_i  (wr_entry),
    .raddr_i  (rd_phys),
    .rdata_o  (rd_entry)
  );

  // Word select happens after the RAM register using the registered select,
  // keeping the whole readback path at one cycle of latency.
  logic [N_WORDS*DATA_W-1:0] rd_padded;

  always_comb begin
    rd_padded              = '0;
    rd_padded[ENTRY_W-1:0] = rd_entry;
    rd_data_o              = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (rd_sel_q == 8'(i)) begin
        rd_data_o = rd_padded[i*DATA_W +: DATA_W];
      end
    end
  end

  assign state_o     = state_q;
  assign stage_o     = stage_q;
  assign trig_addr_o = trig_addr_q;
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_iob_ila_seq_core.sv
// tb_iob_ila_seq_core
//   Directed bench for iob_ila_seq_core with a 16-entry buffer. Each task
//   drives one scenario and compares against hand-derived values. Sample n
//   (1-based, counted from arm) of test t carries signal (t << 24) | n and is
//   written to physical address (n-1) mod 16.
module tb_iob_ila_seq_core;

  localparam int SIGNAL_W  = 32;
  localparam int TRIGGER_W = 4;
  localparam int BUFFER_W  = 4;
  localparam int N_STAGES  = 4;
  localparam int DATA_W    = 32;
  localparam int TS_W      = 16;
  localparam int STG_W     = 3;

  logic                          clk_i = 1'b0;
  logic                          cke_i;
  logic                          arst_n_i;
  logic [SIGNAL_W-1:0]           signal_i;
  logic [TRIGGER_W-1:0]          trigger_i;
  logic                          arm_i;
  logic                          abort_i;
  logic [BUFFER_W-1:0]           pre_samples_i;
  logic [STG_W-1:0]              n_stages_i;
  logic [N_STAGES*TRIGGER_W-1:0] stage_mask_i;
  logic [N_STAGES*TRIGGER_W-1:0] stage_value_i;
  logic [BUFFER_W-1:0]           rd_addr_i;
  logic [7:0]                    rd_sel_i;
  logic [DATA_W-1:0]             rd_data_o;
  logic [2:0]                    state_o;
  logic [STG_W-1:0]              stage_o;
  logic [BUFFER_W-1:0]           trig_addr_o;
  logic                          done_o;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk_i = ~clk_i;

  iob_ila_seq_core #(
    .SIGNAL_W  (SIGNAL_W),
    .TRIGGER_W (TRIGGER_W),
    .BUFFER_W  (BUFFER_W),
    .N_STAGES  (N_STAGES),
    .DATA_W    (DATA_W),
    .TS_W      (TS_W),
    .STG_W     (STG_W)
  ) dut (
    .clk_i         (clk_i),
    .cke_i         (cke_i),
    .arst_n_i      (arst_n_i),
    .signal_i      (signal_i),
    .trigger_i     (trigger_i),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .pre_samples_i (pre_samples_i),
    .n_stages_i    (n_stages_i),
    .stage_mask_i  (stage_mask_i),
    .stage_value_i (stage_value_i),
    .rd_addr_i     (rd_addr_i),
    .rd_sel_i      (rd_sel_i),
    .rd_data_o     (rd_data_o),
    .state_o       (state_o),
    .stage_o       (stage_o),
    .trig_addr_o   (trig_addr_o),
    .done_o        (done_o)
  );

  function automatic logic [31:0] sv(input int t, input int n);
    return (32'(t) << 24) | 32'(n);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample(input logic [31:0] sig, input logic [3:0] trg);
    signal_i  = sig;
    trigger_i = trg;
    tick();
  endtask

  task automatic do_arm(input logic [3:0] pre, input logic [2:0] nst);
    pre_samples_i = pre;
    n_stages_i    = nst;
    arm_i         = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] addr, input logic [7:0] sel,
                           output logic [31:0] data);
    rd_addr_i = addr;
    rd_sel_i  = sel;
    tick();
    data = rd_data_o;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    arst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vec_count++;
    if (state_o !== 3'd0) begin err_count++; $display("FAIL reset_state got=%0d want=0", state_o); end
    vec_count++;
    if (stage_o !== 3'd0) begin err_count++; $display("FAIL reset_stage got=%0d want=0", stage_o); end
    vec_count++;
    if (trig_addr_o !== 4'd0) begin err_count++; $display("FAIL reset_trig got=%0d want=0", trig_addr_o); end
    vec_count++;
    if (done_o !== 1'b0) begin err_count++; $display("FAIL reset_done got=%0b want=0", done_o); end
    vec_count++;
    if (rd_data_o !== 32'h0) begin err_count++; $display("FAIL reset_rdata got=%h want=0", rd_data_o); end
    arst_n_i = 1'b1;
    tick();
    vec_count++;
    if (state_o !== 3'd0) begin err_count++; $display("FAIL idle_after_reset got=%0d want=0", state_o); end
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------
  // P=3, one stage on trigger bit0, trigger on the 10th WAIT sample (#13).
  task automatic test_single_stage();
    logic [31:0] d;
    stage_mask_i  = 16'h0001;
    stage_value_i = 16'h0001;
    do_arm(4'd3, 3'd1);
    vec_count++;
    if (state_o !== 3'd1) begin err_count++; $display("FAIL t1_pre got=%0d want=1", state_o); end
    for (int n = 1; n <= 3; n++) sample(sv(1, n), 4'h0);
    vec_count++;
    if (state_o !== 3'd2) begin err_count++; $display("FAIL t1_wait got=%0d want=2", state_o); end
    for (int n = 4; n <= 13; n++) begin
      sample(sv(1, n), (n == 13) ? 4'h1 : 4'h0);
      if (n == 12) begin
        vec_count++;
        if (state_o !== 3'd2) begin err_count++; $display("FAIL t1_still_wait got=%0d want=2", state_o); end
      end
    end
    vec_count++;
    if (state_o !== 3'd3) begin err_count++; $display("FAIL t1_post got=%0d want=3", state_o); end
    vec_count++;
    if (trig_addr_o !== 4'd12) begin err_count++; $display("FAIL t1_trig_addr got=%0d want=12", trig_addr_o); end
    for (int n = 14; n <= 25; n++) begin
      sample(sv(1, n), 4'h0);
      if (n == 24) begin
        vec_count++;
        if (done_o !== 1'b0) begin err_count++; $display("FAIL t1_done_early got=%0b want=0", done_o); end
      end
    end
    vec_count++;
    if (done_o !== 1'b1 || state_o !== 3'd4) begin
      err_count++; $display("FAIL t1_done got=%0b/%0d want=1/4", done_o, state_o);
    end
    // Logical r holds sample 10+r (three pre samples, trigger at r=3).
    for (int r = 0; r < 16; r++) begin
      read_word(4'(r), 8'd0, d);
      vec_count++;
      if (d !== sv(1, 10 + r)) begin err_count++; $display("FAIL t1_read[%0d] got=%h want=%h", r, d, sv(1, 10 + r)); end
    end
    $display("test_single_stage done");
  endtask

  // ---------------------------------------------------------------------
  // Three stages 1 -> 2 -> 4 with stimulus 1,4,2,2,4 after two pre samples.
  task automatic test_multi_stage();
    logic [31:0] d;
    logic [3:0]  seq [5]       = '{4'h1, 4'h4, 4'h2, 4'h2, 4'h4};
    logic [2:0]  exp_stage [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
    stage_mask_i  = 16'h0FFF;
    stage_value_i = 16'h0421;
    do_arm(4'd2, 3'd3);
    for (int n = 1; n <= 2; n++) sample(sv(2, n), 4'h0);
    vec_count++;
    if (stage_o !== 3'd0 || state_o !== 3'd2) begin
      err_count++; $display("FAIL t2_start got=%0d/%0d want=0/2", stage_o, state_o);
    end
    for (int i = 0; i < 5; i++) begin
      sample(sv(2, 3 + i), seq[i]);
      if (i < 4) begin
        vec_count++;
        if (stage_o !== exp_stage[i] || state_o !== 3'd2) begin
          err_count++; $display("FAIL t2_stage[%0d] got=%0d/%0d want=%0d/2", i, stage_o, state_o, exp_stage[i]);
        end
      end
    end
    vec_count++;
    if (state_o !== 3'd3 || trig_addr_o !== 4'd6) begin
      err_count++; $display("FAIL t2_trigger got=%0d/%0d want=3/6", state_o, trig_addr_o);
    end
    for (int n = 8; n <= 20; n++) sample(sv(2, n), 4'h0);
    vec_count++;
    if (done_o !== 1'b1) begin err_count++; $display("FAIL t2_done got=%0b want=1", done_o); end
    read_word(4'd2, 8'd0, d);
    vec_count++;
    if (d !== sv(2, 7)) begin err_count++; $display("FAIL t2_read_trig got=%h want=%h", d, sv(2, 7)); end
    read_word(4'd0, 8'd0, d);
    vec_count++;
    if (d !== sv(2, 5)) begin err_count++; $display("FAIL t2_read_oldest got=%h want=%h", d, sv(2, 5)); end
    $display("test_multi_stage done");
  endtask

  // ---------------------------------------------------------------------
  // P=DEPTH-1, no stages: trigger on first WAIT sample, no POST.
  task automatic test_max_pre();
    logic [31:0] d;
    do_arm(4'd15, 3'd0);
    for (int n = 1; n <= 15; n++) begin
      sample(sv(3, n), 4'h0);
      if (n == 14) begin
        vec_count++;
        if (state_o !== 3'd1) begin err_count++; $display("FAIL t3_pre got=%0d want=1", state_o); end
      end
    end
    vec_count++;
    if (state_o !== 3'd2) begin err_count++; $display("FAIL t3_wait got=%0d want=2", state_o); end
    sample(sv(3, 16), 4'h0);
    vec_count++;
    if (state_o !== 3'd4 || done_o !== 1'b1) begin
      err_count++; $display("FAIL t3_done got=%0d/%0b want=4/1", state_o, done_o);
    end
    vec_count++;
    if (trig_addr_o !== 4'd15) begin err_count++; $display("FAIL t3_trig_addr got=%0d want=15", trig_addr_o); end
    read_word(4'd15, 8'd0, d);
    vec_count++;
    if (d !== sv(3, 16)) begin err_count++; $display("FAIL t3_read_trig got=%h want=%h", d, sv(3, 16)); end
    read_word(4'd0, 8'd0, d);
    vec_count++;
    if (d !== sv(3, 1)) begin err_count++; $display("FAIL t3_read_oldest got=%h want=%h", d, sv(3, 1)); end
    $display("test_max_pre done");
  endtask

  // ---------------------------------------------------------------------
  // No pre window, trigger on sample 45: pointer wraps, trig addr 12.
  task automatic test_wrap();
    logic [31:0] d;
    stage_mask_i  = 16'h0001;
    stage_value_i = 16'h0001;
    do_arm(4'd0, 3'd1);
    vec_count++;
    if (state_o !== 3'd2) begin err_count++; $display("FAIL t4_wait got=%0d want=2", state_o); end
    for (int n = 1; n <= 45; n++) sample(sv(4, n), (n == 45) ? 4'h1 : 4'h2);
    vec_count++;
    if (state_o !== 3'd3 || trig_addr_o !== 4'd12) begin
      err_count++; $display("FAIL t4_trigger got=%0d/%0d want=3/12", state_o, trig_addr_o);
    end
    for (int n = 46; n <= 60; n++) sample(sv(4, n), 4'h0);
    vec_count++;
    if (done_o !== 1'b1) begin err_count++; $display("FAIL t4_done got=%0b want=1", done_o); end
    read_word(4'd0, 8'd0, d);
    vec_count++;
    if (d !== sv(4, 45)) begin err_count++; $display("FAIL t4_read0 got=%h want=%h", d, sv(4, 45)); end
    read_word(4'd15, 8'd0, d);
    vec_count++;
    if (d !== sv(4, 60)) begin err_count++; $display("FAIL t4_read15 got=%h want=%h", d, sv(4, 60)); end
    $display("test_wrap done");
  endtask

  // ---------------------------------------------------------------------
  // abort together with arm mid-POST, then a clean restart.
  task automatic test_abort();
    logic [31:0] d;
    do_arm(4'd1, 3'd0);
    for (int n = 1; n <= 5; n++) sample(sv(5, n), 4'h0);
    vec_count++;
    if (state_o !== 3'd3) begin err_count++; $display("FAIL t5_in_post got=%0d want=3", state_o); end
    pre_samples_i = 4'd2;
    abort_i = 1'b1;
    arm_i   = 1'b1;
    tick();
    abort_i = 1'b0;
    arm_i   = 1'b0;
    vec_count++;
    if (state_o !== 3'd0 || done_o !== 1'b0) begin
      err_count++; $display("FAIL t5_abort got=%0d/%0b want=0/0", state_o, done_o);
    end
    tick();
    vec_count++;
    if (state_o !== 3'd0) begin err_count++; $display("FAIL t5_stay_idle got=%0d want=0", state_o); end
    do_arm(4'd2, 3'd0);
    for (int n = 1; n <= 16; n++) begin
      sample(sv(5, 100 + n), 4'h0);
      if (n == 15) begin
        vec_count++;
        if (done_o !== 1'b0) begin err_count++; $display("FAIL t5_done_early got=%0b want=0", done_o); end
      end
    end
    vec_count++;
    if (done_o !== 1'b1 || trig_addr_o !== 4'd2) begin
      err_count++; $display("FAIL t5_restart got=%0b/%0d want=1/2", done_o, trig_addr_o);
    end
    read_word(4'd2, 8'd0, d);
    vec_count++;
    if (d !== sv(5, 103)) begin err_count++; $display("FAIL t5_read_trig got=%h want=%h", d, sv(5, 103)); end
    $display("test_abort done");
  endtask

  // ---------------------------------------------------------------------
  // cke low for 5 cycles mid-PRE: no extra entries, no timestamp gap.
  task automatic test_cke_hold();
    logic [31:0] d;
    do_arm(4'd6, 3'd0);
    for (int n = 1; n <= 3; n++) sample(sv(6, n), 4'h0);
    cke_i = 1'b0;
    for (int i = 0; i < 5; i++) sample(32'hDEAD_BEEF, 4'hF);
    vec_count++;
    if (state_o !== 3'd1) begin err_count++; $display("FAIL t6_frozen got=%0d want=1", state_o); end
    cke_i = 1'b1;
    for (int n = 4; n <= 6; n++) sample(sv(6, n), 4'h0);
    vec_count++;
    if (state_o !== 3'd2) begin err_count++; $display("FAIL t6_wait got=%0d want=2", state_o); end
    for (int n = 7; n <= 16; n++) sample(sv(6, n), 4'h0);
    vec_count++;
    if (done_o !== 1'b1 || trig_addr_o !== 4'd6) begin
      err_count++; $display("FAIL t6_done got=%0b/%0d want=1/6", done_o, trig_addr_o);
    end
    // Readback with the clock enable low.
    cke_i = 1'b0;
    for (int r = 0; r < 16; r++) begin
      read_word(4'(r), 8'd0, d);
      vec_count++;
      if (d !== sv(6, r + 1)) begin err_count++; $display("FAIL t6_read[%0d] got=%h want=%h", r, d, sv(6, r + 1)); end
    end
    for (int r = 2; r <= 4; r++) begin
      read_word(4'(r), 8'd1, d);
      vec_count++;
`ifdef IOB_ILA_SEQ_TIMESTAMP_EN
      // Sample r+1 was taken r enabled cycles after arm.
      if (d !== 32'(r)) begin err_count++; $display("FAIL t6_ts[%0d] got=%0d want=%0d", r, d, r); end
`else
      if (d !== 32'h0) begin err_count++; $display("FAIL t6_word1[%0d] got=%h want=0", r, d); end
`endif
    end
    cke_i = 1'b1;
    $display("test_cke_hold done");
  endtask

  initial begin
    cke_i         = 1'b1;
    arst_n_i      = 1'b0;
    signal_i      = '0;
    trigger_i     = '0;
    arm_i         = 1'b0;
    abort_i       = 1'b0;
    pre_samples_i = '0;
    n_stages_i    = '0;
    stage_mask_i  = '0;
    stage_value_i = '0;
    rd_addr_i     = '0;
    rd_sel_i      = '0;

    test_reset();
    test_single_stage();
    test_multi_stage();
    test_max_pre();
    test_wrap();
    test_abort();
    test_cke_hold();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/iob_ila_seq_core.md
# iob_ila_seq_core

Sequenced capture core for the IObundle integrated logic analyser. It samples a SIGNAL_W-wide probe bus into a circular buffer with a programmable pre-trigger window. The capture trigger is a configurable chain of up to N_STAGES masked trigger-pattern matches rather than a single combined trigger. It sits below the ILA register file: software arms it, polls status, and reads back samples in chronological order.

## Interface
- SIGNAL_W, 32, probe bus width
- TRIGGER_W, 4, trigger input width
- BUFFER_W, 10, log2 of buffer depth; DEPTH = 2^BUFFER_W entries
- N_STAGES, 4, maximum trigger-sequencer stages; STG_W = $clog2(N_STAGES+1)
- DATA_W, 32, readback word width
- TS_W, 16, timestamp width (only used with timestamps enabled)
- clk_i  in  1  single clock for sampling and readback
- cke_i  in  1  clock enable
- arst_n_i  in  1  reset, asynchronous and active-low
- signal_i  in  SIGNAL_W  probe bus
- trigger_i  in  TRIGGER_W  trigger inputs
- arm_i  in  1  pulse: start a capture (also restarts an active one)
- abort_i  in  1  pulse: return to IDLE
- pre_samples_i  in  BUFFER_W  samples kept before the trigger
- n_stages_i  in  STG_W  active stage count (0 means trigger immediately)
- stage_mask_i  in  N_STAGES*TRIGGER_W  per-stage care mask; stage k is slice k
- stage_value_i  in  N_STAGES*TRIGGER_W  per-stage match value
- rd_addr_i  in  BUFFER_W  logical sample index; 0 is the oldest sample
- rd_sel_i  in  8  DATA_W word select within one entry
- rd_data_o  out  DATA_W  readback word
- state_o  out  3  FSM state
- stage_o  out  STG_W  current sequencer stage
- trig_addr_o  out  BUFFER_W  physical address of the trigger sample
- done_o  out  1  capture complete

## Operation
- FSM encoding: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4. Every register resets to 0, so after reset the state is IDLE and all outputs are 0.
- Priority: abort_i beats arm_i. Abort from any state goes to IDLE and clears done_o. arm_i in any state:
  - clears the write pointer, stage and counters;
  - goes to PRE, or to WAIT if pre_samples_i==0.
- Effective pre count P = min(pre_samples_i, DEPTH-1). It is latched when arm_i is accepted.
- PRE: write one entry per enabled cycle. After P writes, go to WAIT.
- WAIT: keep writing circularly, overwriting the oldest entries.
  - Stage k matches when &(~(trigger_i ^ value_k) | ~mask_k). A mask of 0 always matches.
  - If the current stage matches and is not the last (n_stages_i-1), the stage increments.
  - If the last stage matches, the sample written that same cycle is the trigger sample. Latch trig_addr_o = wptr and go to POST.
  - If n_stages_i==0, the first WAIT sample is the trigger sample.
  - Each sample advances the stage by at most one.
  - n_stages_i > N_STAGES is treated as N_STAGES.
- POST: write DEPTH-1-P more samples, then go to DONE. If that count is 0, go straight to DONE. done_o=1 in DONE, and writes stop.
- Readback: physical address = (trig_addr_o - P + rd_addr_i) mod DEPTH. It wraps naturally in BUFFER_W bits.
- Entry layout: bits [SIGNAL_W-1:0] hold signal_i, with the timestamp above them when enabled. rd_sel_i selects bits [rd_sel*DATA_W +: DATA_W], zero-extended past the entry width.
- Readback works in every state. Data is only meaningful in DONE.
- cke_i=0 freezes the FSM, pointer, counters and timestamp. Readback still works.

## Timing
- Capture has zero latency: signal_i and trigger_i sampled in the same cycle form one entry.
- A stage advance is visible on stage_o in the next cycle.
- rd_data_o is registered, with 1-cycle latency from rd_addr_i/rd_sel_i.
- state_o, stage_o and done_o change on the clock edge after the event that causes them.
- Arm to DONE takes exactly DEPTH enabled cycles if the trigger sequence completes as soon as possible (trigger on the first WAIT cycle).

## Configuration
- IOB_ILA_SEQ_TIMESTAMP_EN defined:
  - a TS_W free-running counter, cleared on arm, increments each enabled cycle and wraps;
  - each entry becomes {ts, signal}, entry width SIGNAL_W+TS_W.
- Undefined: no counter; entry width is SIGNAL_W.

## Structure
- Shared package iob_ila_seq_pkg holds:
  - the state encodings (IDLE..DONE);
  - the entry-width macro;
  - the word-count macro ceil(entry/DATA_W).
- One sub-module, iob_ila_seq_mem: a DEPTH x entry-width single-write, single-read synchronous RAM with registered read.

## Test plan
- BUFFER_W=4, P=3, n_stages=1, mask=4'h1, value=4'h1, trigger bit0 high in the 10th WAIT cycle. Expected: done after 12 more samples; rd_addr 3 returns the trigger sample; rd_addr 0..2 return the three samples before it.
- 3 stages with values 1, 2, 4 (full mask), stimulus 1, 4, 2, 2, 4. Expected: stage_o goes 0→1, stays 1, 1→2, stays 2; the trigger is the final 4.
- P=15 (DEPTH-1), n_stages=0. Expected: 15 PRE writes, the trigger at the first WAIT cycle, POST count 0, done immediately after; rd_addr 15 is the trigger sample.
- pre_samples_i=0 and a long WAIT (more than 40 samples). Expected: the pointer wraps; trig_addr_o is non-zero; rd_addr 0 returns the trigger sample.
- abort_i asserted mid-POST together with arm_i. Expected: IDLE, done_o=0. A later arm restarts cleanly.
- cke_i held low for 5 cycles mid-PRE. Expected: no extra entries and the timestamp gap is 0. With IOB_ILA_SEQ_TIMESTAMP_EN, consecutive timestamps differ by 1.
